fpu_rr_arbiter: RTL
===================

FPU_RR_ARBITER -- requirements
Module: fpu_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one fpnew_top instance.
REQ-002 Parameter WIDTH, default 32: operand/result width (FP32).
REQ-003 Parameter NUM_OPERANDS, default 3: operands per request.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum requests in flight inside the FPU.
REQ-005 Local TAG_W = max(1, clog2(NUM_REQ)); CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 req_valid_i  in  NUM_REQ  per-requester request valid.
REQ-009 req_ready_o  out  NUM_REQ  per-requester request accepted this cycle.
REQ-010 req_operands_i  in  NUM_REQ x NUM_OPERANDS x WIDTH  per-requester operands.
REQ-011 rsp_valid_o  out  NUM_REQ  result valid, one-hot or zero.
REQ-012 rsp_ready_i  in  NUM_REQ  per-requester result ready.
REQ-013 rsp_result_o  out  WIDTH  shared result bus.
REQ-014 rsp_status_o  out  5  shared status flags (NV,DZ,OF,UF,NX).
REQ-015 drain_i  in  1  block new issues while high.
REQ-016 fpu_operands_o  out  NUM_OPERANDS x WIDTH  to FPU operands_i.
REQ-017 fpu_tag_o  out  TAG_W  to FPU tag_i: granted requester index.
REQ-018 fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake.
REQ-019 fpu_result_i / fpu_status_i / fpu_tag_i  in  WIDTH/5/TAG_W  FPU outputs.
REQ-020 fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake.
REQ-021 outstanding_o  out  CNT_W  requests in flight; busy_o  out  1  = (outstanding_o != 0).

Function
REQ-022 Issue enable en = !rst_i && !drain_i && (outstanding < MAX_OUTSTANDING).
REQ-023 Grant: combinational round-robin, first asserted req_valid_i scanning from index ptr upward with wrap; grant only when en.
REQ-024 fpu_in_valid_o = en && |req_valid_i; fpu_operands_o/fpu_tag_o = granted requester's operands/index; zero when no grant.
REQ-025 req_ready_o[g] = granted && fpu_in_ready_i; all other bits 0; never depends on req_valid_i of non-granted requesters.
REQ-026 Issue event = fpu_in_valid_o && fpu_in_ready_i; on issue ptr <= (g+1) mod NUM_REQ; otherwise ptr holds.
REQ-027 Grant SHALL remain stable while fpu_in_valid_o high and fpu_in_ready_i low, provided requesters hold valid (ptr unchanged).
REQ-028 Response routing combinational: rsp_valid_o[fpu_tag_i] = fpu_out_valid_i; rsp_result_o = fpu_result_i; rsp_status_o = fpu_status_i; fpu_out_ready_o = rsp_ready_i[fpu_tag_i].
REQ-029 fpu_tag_i >= NUM_REQ: fpu_out_ready_o = 1, rsp_valid_o = 0 (result dropped, counter still decremented).
REQ-030 Retire event = fpu_out_valid_i && fpu_out_ready_o.
REQ-031 Counter: issue only -> +1; retire only -> -1; both same cycle -> unchanged; neither -> hold.
REQ-032 Counter full (== MAX_OUTSTANDING): no issue that cycle, even if a retire occurs simultaneously; issue resumes next cycle.
REQ-033 Retire with counter 0: counter saturates at 0 (protocol error, no underflow).
REQ-034 drain_i asserted mid-handshake: fpu_in_valid_o drops same cycle; in-flight results still routed and retired.
REQ-035 Latency: zero cycles added in both directions (pure combinational steering); only ptr and counter are registered.

Reset
REQ-036 While rst_i high: ptr = 0, outstanding_o = 0, busy_o = 0, fpu_in_valid_o = 0, req_ready_o = 0; response path stays combinational per REQ-028.
REQ-037 Reset asserted mid-operation discards all state; in-flight FPU results arriving after release are routed normally; counter saturates per REQ-033.
REQ-038 First grant after reset favours requester 0.

Verification
REQ-039 Both requesters valid continuously, fpu_in_ready_i=1, FPU latency 2 -> grants alternate 0,1,0,1; outstanding_o reaches 2 and holds.
REQ-040 Requester 0 only, fpu_out_ready blocked (rsp_ready_i=0) -> exactly 4 issues, then fpu_in_valid_o=0, outstanding_o=4, busy_o=1.
REQ-041 Counter at 4, retire cycle with pending request -> no issue that cycle, outstanding_o=3, issue next cycle returns it to 4.
REQ-042 fpu_in_ready_i=0 for 3 cycles with both valid -> tag and operands stable, req_ready_o=00, ptr unchanged.
REQ-043 Result tag 1, rsp_ready_i=10 -> rsp_valid_o=10, fpu_out_ready_o=1; rsp_ready_i=01 -> fpu_out_ready_o=0, result held.
REQ-044 rst_i pulsed with outstanding_o=3 -> outstanding_o=0, ptr=0 immediately; next grant requester 0.

Source files
------------

// File: rtl/fpu_rr_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one FPU instance.
// Issue and response steering are purely combinational; only the grant pointer and in-flight count are registered.
module fpu_rr_arbiter #(
  parameter  int NUM_REQ         = 2,
  parameter  int WIDTH           = 32,
  parameter  int NUM_OPERANDS    = 3,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int TAG_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NUM_REQ-1:0]                              req_valid_i,
  output logic [NUM_REQ-1:0]                              req_ready_o,
  input  logic [NUM_REQ-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] req_operands_i,
  output logic [NUM_REQ-1:0]                              rsp_valid_o,
  input  logic [NUM_REQ-1:0]                              rsp_ready_i,
  output logic [WIDTH-1:0]                                rsp_result_o,
  output logic [4:0]                                      rsp_status_o,
  input  logic                                            drain_i,
  output logic [NUM_OPERANDS-1:0][WIDTH-1:0]              fpu_operands_o,
  output logic [TAG_W-1:0]                                fpu_tag_o,
  output logic                                            fpu_in_valid_o,
  input  logic                                            fpu_in_ready_i,
  input  logic [WIDTH-1:0]                                fpu_result_i,
  input  logic [4:0]                                      fpu_status_i,
  input  logic [TAG_W-1:0]                                fpu_tag_i,
  input  logic                                            fpu_out_valid_i,
  output logic                                            fpu_out_ready_o,
  output logic [CNT_W-1:0]                                outstanding_o,
  output logic                                            busy_o
);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] ptr_nxt;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [CNT_W-1:0] outstanding;
  logic             en;
  logic             issue;
  logic             retire;
  int               idx;

  // Full counter blocks issue even when a retire lands in the same cycle.
  assign en = !rst_i && !drain_i && (outstanding < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_vld && req_valid_i[i] && (idx == i)) begin
          gnt_vld = 1'b1;
          gnt_idx = TAG_W'(i);
        end
      end
    end
    gnt_vld = gnt_vld && en;
  end

  always_comb begin
    fpu_in_valid_o = gnt_vld;
    fpu_tag_o      = gnt_vld ? gnt_idx : '0;
    fpu_operands_o = '0;
    req_ready_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == TAG_W'(i))) begin
        req_ready_o[i] = fpu_in_ready_i;
        fpu_operands_o = req_operands_i[i];
      end
    end
    ptr_nxt = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Out-of-range tags are accepted and dropped so the FPU never stalls on them.
  always_comb begin
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fpu_tag_i == TAG_W'(i)) begin
        rsp_valid_o[i]  = fpu_out_valid_i;
        fpu_out_ready_o = rsp_ready_i[i];
      end
    end
  end

  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;

  assign issue  = fpu_in_valid_o && fpu_in_ready_i;
  assign retire = fpu_out_valid_i && fpu_out_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr         <= '0;
      outstanding <= '0;
    end else begin
      if (issue) ptr <= ptr_nxt;
      case ({issue, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign outstanding_o = outstanding;
  assign busy_o        = (outstanding != '0);

endmodule
